period_meter_p16: RTL and testbench

PERIOD_METER_P16 -- requirements
Module: period_meter_p16

---
 rtl/sig_p16_pkg.sv | 21 ++
 rtl/first_set_p16.sv | 28 ++
 rtl/period_meter_p16.sv | 133 +++++++++++++
 tb/tb_period_meter_p16.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sig_p16_pkg.sv
// Shared definitions for the 16-lane parallel-sample period meter.
// Lane count, timestamp width, meter states and a one-hot helper.
package sig_p16_pkg;

  localparam int LANES = 16;
  localparam int TS_W  = 32;
  localparam int IDX_W = $clog2(LANES);

  typedef logic [TS_W-1:0] ts_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } meter_state_e;

  function automatic logic [LANES-1:0] lane_onehot(input logic [IDX_W-1:0] idx);
    return LANES'(1) << idx;
  endfunction

endpackage

// File: rtl/first_set_p16.sv
// Lowest-set-bit finder over a masked 16-bit vector.
// Returns a found flag and the index of the lowest surviving bit.
module first_set_p16
  import sig_p16_pkg::*;
(
  input  logic [LANES-1:0] vec_i,
  input  logic [LANES-1:0] mask_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [LANES-1:0] hits;

  assign hits = vec_i & mask_i;

  // Scan from the top so the last assignment wins at the lowest index.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (hits[i]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/period_meter_p16.sv
// Period meter for a 16-sub-sample-per-cycle feedback signal: rising-edge
// timestamping with holdoff, two-stage output pipeline and loss-of-signal.
//
// state  | meaning
// IDLE   | no reference edge; next rising edge is accepted and arms
// ARMED  | one reference edge held; next qualified edge gives a period
// LOCKED | periods are being measured on every qualified edge
module period_meter_p16
  import sig_p16_pkg::*;
#(
  parameter int MIN_PERIOD = 32,
  parameter int TIMEOUT    = 65536
) (
  input  logic             p_clock,
  input  logic             reset,
  input  logic [LANES-1:0] p_in,
  output logic [LANES-1:0] p_edge,
  output logic [TS_W-1:0]  period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam ts_t MIN_TS     = ts_t'(MIN_PERIOD);
  localparam ts_t TIMEOUT_TS = ts_t'(TIMEOUT);

  meter_state_e state_q, state_d;
  ts_t          time_base_q, last_ts_q, prev_ts_q, period_q;
  logic         prev_bit_q;

  logic [LANES-1:0] s1_edge_q, s1_edge_d, p_edge_q;
  logic             s1_pv_q, s1_pv_d, s1_to_q, s1_to_d, pv_q, to_q;

  logic [LANES-1:0] rise, qual;
  logic             found;
  logic [IDX_W-1:0] idx;
  ts_t              edge_ts;
  logic             expired;

  assign rise = p_in & ~{p_in[LANES-2:0], prev_bit_q};

  // Holdoff is measured per lane against the lane's own timestamp.
  always_comb begin
    qual = '0;
    for (int i = 0; i < LANES; i++) begin
      qual[i] = (state_q == IDLE) || ((time_base_q + ts_t'(i) - last_ts_q) >= MIN_TS);
    end
  end

  first_set_p16 u_first (
    .vec_i   (rise),
    .mask_i  (qual),
    .found_o (found),
    .idx_o   (idx)
  );

  assign edge_ts = time_base_q + ts_t'(idx);
  assign expired = (time_base_q - last_ts_q) >= TIMEOUT_TS;

  always_comb begin
    state_d   = state_q;
    s1_edge_d = '0;
    s1_pv_d   = 1'b0;
    s1_to_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = ARMED;
          s1_edge_d = lane_onehot(idx);
        end
      end
      ARMED, LOCKED: begin
        if (found) begin
          state_d   = LOCKED;
          s1_edge_d = lane_onehot(idx);
          s1_pv_d   = 1'b1;
        end else if (expired) begin
          state_d = IDLE;
          s1_to_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      time_base_q <= '0;
      last_ts_q   <= '0;
      prev_ts_q   <= '0;
      prev_bit_q  <= 1'b1;
      s1_edge_q   <= '0;
      s1_pv_q     <= 1'b0;
      s1_to_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_base_q <= time_base_q + ts_t'(LANES);
      prev_bit_q  <= p_in[LANES-1];
      s1_edge_q   <= s1_edge_d;
      s1_pv_q     <= s1_pv_d;
      s1_to_q     <= s1_to_d;
      if (found) begin
        prev_ts_q <= last_ts_q;
        last_ts_q <= edge_ts;
      end
    end
  end

  // Stage 2: the difference is taken from the timestamps stage 1 just stored.
  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) begin
      p_edge_q <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      p_edge_q <= s1_edge_q;
      pv_q     <= s1_pv_q;
      to_q     <= s1_to_q;
      if (s1_pv_q) begin
        period_q <= last_ts_q - prev_ts_q;
      end
    end
  end

  assign p_edge       = p_edge_q;
  assign period_out   = period_q;
  assign period_valid = pv_q;
  assign timeout      = to_q;
  assign locked       = (state_q == LOCKED);

endmodule

// File: tb/tb_period_meter_p16.sv
// Directed bench for period_meter_p16 with a per-word reference model
// feeding a scoreboard that is checked against the stage-2 outputs.
module tb_period_meter_p16;

  localparam int MINP = 32;
  localparam int TMO  = 65536;

  logic        p_clock = 1'b0;
  logic        reset   = 1'b1;
  logic [15:0] p_in    = 16'h0000;
  logic [15:0] p_edge;
  logic [31:0] period_out;
  logic        period_valid;
  logic        locked;
  logic        timeout;

  always #5 p_clock = ~p_clock;

  period_meter_p16 #(.MIN_PERIOD(MINP), .TIMEOUT(TMO)) dut (
    .p_clock      (p_clock),
    .reset        (reset),
    .p_in         (p_in),
    .p_edge       (p_edge),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  typedef struct {
    logic [15:0] pe;
    logic        pv;
    logic        to;
    logic [31:0] period;
    int          widx;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [31:0] m_tb, m_last, m_period;
  logic        m_prev_bit;
  int          m_state;
  int          word_cnt = 0;

  logic [15:0] o_pe;
  logic        o_pv, o_to;
  logic [31:0] o_per;
  int          o_widx;
  int          g_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_t e;
    m_tb       = 32'd0;
    m_last     = 32'd0;
    m_period   = 32'd0;
    m_prev_bit = 1'b1;
    m_state    = 0;
    sb.delete();
    e.pe = 16'h0; e.pv = 1'b0; e.to = 1'b0; e.period = 32'd0; e.widx = -1;
    sb.push_back(e);
  endtask

  task automatic model_word(input logic [15:0] w, output exp_t e);
    logic        found;
    logic        pb;
    int          idx;
    logic [31:0] ts;
    logic [31:0] acc_ts;
    found  = 1'b0;
    idx    = 0;
    acc_ts = 32'd0;
    for (int i = 0; i < 16; i++) begin
      pb = (i == 0) ? m_prev_bit : w[i-1];
      ts = m_tb + 32'(i);
      if (!found && w[i] && !pb && (m_state == 0 || (ts - m_last) >= 32'(MINP))) begin
        found  = 1'b1;
        idx    = i;
        acc_ts = ts;
      end
    end
    e.pe = found ? (16'h0001 << idx) : 16'h0000;
    e.pv = found && (m_state != 0);
    e.to = 1'b0;
    if (found) begin
      if (m_state != 0) m_period = acc_ts - m_last;
      m_last  = acc_ts;
      m_state = (m_state == 0) ? 1 : 2;
    end else if (m_state != 0 && (m_tb - m_last) >= 32'(TMO)) begin
      m_state = 0;
      e.to    = 1'b1;
    end
    e.period   = m_period;
    e.widx     = word_cnt;
    word_cnt++;
    m_prev_bit = w[15];
    m_tb       = m_tb + 32'd16;
  endtask

  task automatic step(input logic [15:0] w);
    exp_t e;
    exp_t x;
    p_in = w;
    model_word(w, e);
    sb.push_back(e);
    @(posedge p_clock);
    #1;
    x = sb.pop_front();
    chk("p_edge", 32'(p_edge), 32'(x.pe));
    chk("period_valid", 32'(period_valid), 32'(x.pv));
    chk("timeout", 32'(timeout), 32'(x.to));
    chk("period_out", period_out, x.period);
    o_pe   = p_edge;
    o_pv   = period_valid;
    o_to   = timeout;
    o_per  = period_out;
    o_widx = x.widx;
  endtask

  function automatic logic [15:0] gen_word(input int t, input int per);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[i] = (((t + i) % per) < (per / 2));
    return w;
  endfunction

  task automatic step_gen();
    step(gen_word(g_t, 1600));
    g_t += 16;
  endtask

  task automatic reset_zero_checks();
    chk("rst p_edge", 32'(p_edge), 32'd0);
    chk("rst period_out", period_out, 32'd0);
    chk("rst period_valid", 32'(period_valid), 32'd0);
    chk("rst locked", 32'(locked), 32'd0);
    chk("rst timeout", 32'(timeout), 32'd0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    reset_zero_checks();
    @(posedge p_clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int pv_cnt, last_pv, edge_word, to_cnt, to_word, edges_seen, first_pv_edges;

    #1;
    reset_zero_checks();
    @(posedge p_clock);
    #1 reset = 1'b0;
    model_reset();

    // Line already high at release, then two edges in one word while idle.
    step(16'hFFFF);
    step(16'h0000);
    chk("high at release no edge", 32'(o_pe), 32'h0);
    step(16'h1E38);
    step(16'h0000);
    chk("two edges p_edge", 32'(o_pe), 32'h0008);
    chk("two edges no period_valid", 32'(o_pv), 32'd0);
    chk("two edges state armed", 32'(dut.state_q), 32'd1);
    chk("two edges locked", 32'(locked), 32'd0);

    // Loopback from the generator at period 1600.
    do_reset();
    g_t     = 800;
    pv_cnt  = 0;
    last_pv = -1;
    for (int j = 0; j < 450; j++) begin
      step_gen();
      if (o_pv) begin
        chk("loop period_out", o_per, 32'd1600);
        chk("loop locked", 32'(locked), 32'd1);
        if (pv_cnt > 0) chk("loop strobe spacing", 32'(o_widx - last_pv), 32'd100);
        last_pv = o_widx;
        pv_cnt++;
      end
    end
    chk("loop strobe count", 32'(pv_cnt), 32'd3);

    // Edge at lane 15, then lane 0 101 words later.
    do_reset();
    step(16'h0000);
    step(16'h8000);
    step(16'h0000);
    chk("lane15 p_edge", 32'(o_pe), 32'h8000);
    for (int j = 0; j < 99; j++) step(16'h0000);
    step(16'h0001);
    step(16'h0010);
    chk("wrap p_edge", 32'(o_pe), 32'h0001);
    chk("wrap period_valid", 32'(o_pv), 32'd1);
    chk("wrap period_out", o_per, 32'd1601);
    chk("wrap locked", 32'(locked), 32'd1);

    // Glitch 20 sub-samples after the accepted edge is ignored.
    step(16'h0000);
    chk("glitch p_edge", 32'(o_pe), 32'h0);
    chk("glitch period_valid", 32'(o_pv), 32'd0);
    for (int j = 0; j < 97; j++) step(16'h0000);
    step(16'h0001);
    edge_word = word_cnt - 1;
    step(16'h0000);
    chk("after glitch p_edge", 32'(o_pe), 32'h0001);
    chk("after glitch period_out", o_per, 32'd1600);

    // Input held low: one timeout, 4096 words after the last edge.
    to_cnt  = 0;
    to_word = -1;
    for (int j = 0; j < 4200; j++) begin
      step(16'h0000);
      if (o_to) begin
        to_cnt++;
        to_word = o_widx;
        chk("timeout locked", 32'(locked), 32'd0);
        chk("timeout period held", o_per, 32'd1600);
      end
    end
    chk("timeout count", 32'(to_cnt), 32'd1);
    chk("timeout delay words", 32'(to_word - edge_word), 32'd4096);
    chk("post timeout locked", 32'(locked), 32'd0);
    chk("post timeout period_out", period_out, 32'd1600);

    // Reset while locked, released into a running input.
    do_reset();
    g_t = 0;
    for (int j = 0; j < 260; j++) step_gen();
    chk("pre reset locked", 32'(locked), 32'd1);
    chk("pre reset period_out", period_out, 32'd1600);
    do_reset();
    edges_seen     = 0;
    first_pv_edges = -1;
    for (int j = 0; j < 300; j++) begin
      step_gen();
      if (o_pe != 16'h0) begin
        edges_seen++;
        if (first_pv_edges < 0 && !o_pv) chk("post reset period_out", o_per, 32'd0);
      end
      if (o_pv && first_pv_edges < 0) begin
        first_pv_edges = edges_seen;
        chk("post reset first period", o_per, 32'd1600);
      end
    end
    chk("post reset edges to first strobe", 32'(first_pv_edges), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
